placement_eval: RTL and testbench
=================================

Name: placement_eval

Overview:
- Post-placement wirelength evaluator. Sits directly downstream of the placement engine.
- Once placement finishes, walks the edge list through the edge ROMs (A/B endpoints) and the pos_X/pos_Y RAMs.
- Accumulates Manhattan and 1-hop cost, max edge length, unplaced-node count and out-of-grid count.
- Frees the placement FSM from evaluation; results are held for the top level and the bench.

Parameters:
- N, 7, grid side length; valid coordinates are 0..N-1.
- W, 32, data/address width of all memory ports and accumulators.
- CNT_W, 16, width of edge_count and of both count outputs.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; resets all state and outputs.
- start  in  1  1-cycle pulse; honoured only in IDLE.
- edge_count  in  CNT_W  number of edges; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted through DONE.
- done  out  1  1-cycle pulse when results are valid.
- reEA, reEB  out  1  edge ROM read strobes.
- addrEA, addrEB  out  W  edge index.
- doutEA, doutEB  in  W  node ids of endpoints A/B.
- rePX, rePY  out  1  position RAM read strobes.
- addrPX, addrPY  out  W  node id.
- doutPX, doutPY  in  W  signed coordinate; -1 means unplaced.
- sum  out  W  signed; sum over edges of (|dx|+|dy|-1).
- sum_1hop  out  W  signed; sum over edges of (ceil(|dx|/2)+ceil(|dy|/2)-1).
- max_len  out  W  largest |dx|+|dy| over counted edges.
- unplaced_cnt  out  CNT_W  edges skipped because an endpoint coordinate is -1.
- bad_cnt  out  CNT_W  edges skipped because a coordinate is outside 0..N-1 (and not -1).

Behaviour:
- Reset values: all outputs 0, state IDLE, edge index i = 0.
- Memory timing: strobes and addresses are registered outputs. A strobe is high for exactly one cycle. dout is valid from the next rising edge and held until the next read.
- FSM: IDLE -> E_REQ -> E_WAIT -> A_REQ -> A_WAIT -> B_REQ -> B_WAIT -> CALC -> ACC -> (E_REQ | DONE) -> IDLE.
- IDLE:
  - On start: clear sum, sum_1hop, max_len and both counts; latch edge_count; i <= 0.
  - Go to E_REQ, or to DONE if edge_count == 0.
- E_REQ: reEA = reEB = 1, addrEA = addrEB = i.
- A_REQ: latch node ids a, b; rePX = rePY = 1 at address a.
- B_REQ: latch ax, ay; read position RAMs at address b.
- CALC:
  - Latch bx, by.
  - dx = |ax-bx|, dy = |ay-by|, two's-complement absolute value.
  - Classify: unplaced if any coordinate == -1; else bad if any coordinate < 0 or >= N; else valid.
- ACC:
  - valid: sum += dx+dy-1; sum_1hop += (dx>>1)+dx[0] + (dy>>1)+dy[0] - 1; max_len = max(max_len, dx+dy).
  - unplaced: unplaced_cnt++. bad: bad_cnt++.
  - Unplaced takes priority over bad; exactly one of the three outcomes per edge.
  - Then i++. Go to DONE if i+1 == latched count, else E_REQ.
- Cost and latency:
  - Each edge costs exactly 8 cycles.
  - done is high in cycle 8*edge_count+1 after the start-accepting edge.
  - DONE: done = 1 for one cycle, busy = 0 next cycle; outputs hold until the next accepted start.
- Boundaries:
  - start while busy is ignored.
  - Coincident endpoints (dx = dy = 0) contribute -1 to both sums; this is intentional.
  - Accumulators wrap mod 2^W with no saturation.
  - Counts wrap mod 2^CNT_W.
  - Reset mid-run aborts immediately; no done pulse is produced.

Decomposition:
- Shared package placement_pkg:
  - Grid constant N.
  - UNPLACED = -1.
  - Memory width W.
  - State encoding enum shared with the placement FSM numbering style.
- One natural sub-module, edge_cost:
  - Combinational.
  - Takes ax, ay, bx, by; returns dx+dy, the 1-hop term and the valid/unplaced/bad class.
  - Instantiated in CALC.

Test Plan:
- Single edge (0,1), pos0=(0,0), pos1=(3,4), count 1 -> done at cycle 9; sum=6, sum_1hop=3, max_len=7, counts 0.
- Two edges (0,1),(1,2), pos (0,0),(1,0),(1,1) -> sum=0, sum_1hop=0, max_len=1, done at cycle 17.
- Edge with pos1=(-1,-1) plus edge with pos=(7,2) at N=7 -> unplaced_cnt=1, bad_cnt=1, sum=0.
- edge_count=0 -> done at cycle 1, all results 0, no memory strobes issued.
- start re-pulsed at cycle 4 of a 3-edge run -> ignored, single done at cycle 25; then reset asserted at cycle 10 of a new run -> busy=0, outputs 0, no done.
- Self-loop edge (2,2) -> sum=-1, sum_1hop=-1, max_len=0.

Source files
------------

// File: rtl/placement_eval_pkg.sv
// Shared constants, FSM state encoding and edge classification for the
// post-placement wirelength evaluator.
package placement_pkg;

   localparam int GRID_N   = 7;
   localparam int MEM_W    = 32;
   localparam int COUNT_W  = 16;
   localparam int UNPLACED = -1;

   // Numbered explicitly so debug dumps line up with the placement FSM's style.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_E_REQ  = 4'd1,
      S_E_WAIT = 4'd2,
      S_A_REQ  = 4'd3,
      S_A_WAIT = 4'd4,
      S_B_REQ  = 4'd5,
      S_B_WAIT = 4'd6,
      S_CALC   = 4'd7,
      S_ACC    = 4'd8,
      S_DONE   = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      CLS_VALID    = 2'd0,
      CLS_UNPLACED = 2'd1,
      CLS_BAD      = 2'd2
   } edge_class_t;

endpackage

// File: rtl/placement_eval_if.sv
// Read ports of the edge ROMs (A/B endpoints) and the pos_X/pos_Y RAMs.
// Handshake: a strobe is high for one cycle with its address; dout is valid
// from the next rising edge and held until the next read on that port.
interface placement_eval_if #(
   parameter int W = placement_pkg::MEM_W
);
   logic         reEA, reEB, rePX, rePY;
   logic [W-1:0] addrEA, addrEB, addrPX, addrPY;
   logic [W-1:0] doutEA, doutEB, doutPX, doutPY;

   modport master (
      output reEA, reEB, rePX, rePY,
      output addrEA, addrEB, addrPX, addrPY,
      input  doutEA, doutEB, doutPX, doutPY
   );

   modport slave (
      input  reEA, reEB, rePX, rePY,
      input  addrEA, addrEB, addrPX, addrPY,
      output doutEA, doutEB, doutPX, doutPY
   );
endinterface

// File: rtl/placement_eval_edge_cost.sv
// Combinational per-edge cost: Manhattan length, 1-hop term and the
// valid/unplaced/bad classification of the two endpoint coordinates.
module edge_cost
   import placement_pkg::*;
#(
   parameter int N = GRID_N,
   parameter int W = MEM_W
) (
   input  logic [W-1:0] ax,
   input  logic [W-1:0] ay,
   input  logic [W-1:0] bx,
   input  logic [W-1:0] by,
   output logic [W-1:0] len,
   output logic [W-1:0] hop,
   output edge_class_t  cls
);

   logic [W-1:0] dx_raw, dy_raw, dx, dy;
   logic         any_unplaced, any_bad;

   // Negative or at/after the grid edge; -1 is filtered out earlier by priority.
   function automatic logic off_grid(input logic [W-1:0] c);
      return c[W-1] || (c >= W'(N));
   endfunction

   always_comb begin
      dx_raw = ax - bx;
      dy_raw = ay - by;
      dx     = dx_raw[W-1] ? (~dx_raw + W'(1)) : dx_raw;
      dy     = dy_raw[W-1] ? (~dy_raw + W'(1)) : dy_raw;
      len    = dx + dy;
      // ceil(d/2) per axis; coincident endpoints deliberately give -1.
      hop    = (dx >> 1) + W'(dx[0]) + (dy >> 1) + W'(dy[0]) - W'(1);

      any_unplaced = (ax == W'(UNPLACED)) || (ay == W'(UNPLACED)) ||
                     (bx == W'(UNPLACED)) || (by == W'(UNPLACED));
      any_bad      = off_grid(ax) || off_grid(ay) || off_grid(bx) || off_grid(by);

      if (any_unplaced)
         cls = CLS_UNPLACED;
      else if (any_bad)
         cls = CLS_BAD;
      else
         cls = CLS_VALID;
   end

endmodule

// File: rtl/placement_eval.sv
// Walks the edge list after placement, fetching endpoints and their positions,
// and accumulates wirelength statistics. Eight cycles per edge.
module placement_eval
   import placement_pkg::*;
#(
   parameter int N     = GRID_N,
   parameter int W     = MEM_W,
   parameter int CNT_W = COUNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] edge_count,
   output logic             busy,
   output logic             done,
   placement_eval_if.master mem,
   output logic [W-1:0]     sum,
   output logic [W-1:0]     sum_1hop,
   output logic [W-1:0]     max_len,
   output logic [CNT_W-1:0] unplaced_cnt,
   output logic [CNT_W-1:0] bad_cnt,
   output state_t           state_dbg
);

   state_t           state, next_state;
   logic [CNT_W-1:0] i, i_next, count_q;
   logic             last_edge;
   logic [W-1:0]     b_q, ax_q, ay_q, bx_q, by_q;
   logic [W-1:0]     len_q, hop_q;
   edge_class_t      cls_q;
   logic [W-1:0]     cost_len, cost_hop;
   edge_class_t      cost_cls;

   assign state_dbg = state;
   assign i_next    = i + CNT_W'(1);
   assign last_edge = (i_next == count_q);

   edge_cost #(.N(N), .W(W)) u_edge_cost (
      .ax  (ax_q),
      .ay  (ay_q),
      .bx  (bx_q),
      .by  (by_q),
      .len (cost_len),
      .hop (cost_hop),
      .cls (cost_cls)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:   if (start) next_state = (edge_count == '0) ? S_DONE : S_E_REQ;
         S_E_REQ:  next_state = S_E_WAIT;
         S_E_WAIT: next_state = S_A_REQ;
         S_A_REQ:  next_state = S_A_WAIT;
         S_A_WAIT: next_state = S_B_REQ;
         S_B_REQ:  next_state = S_B_WAIT;
         S_B_WAIT: next_state = S_CALC;
         S_CALC:   next_state = S_ACC;
         S_ACC:    next_state = last_edge ? S_DONE : S_E_REQ;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Strobes are launched on the edge entering the *_REQ state, so each is
   // high for exactly the REQ cycle and data lands in the following WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy         <= 1'b0;
         done         <= 1'b0;
         sum          <= '0;
         sum_1hop     <= '0;
         max_len      <= '0;
         unplaced_cnt <= '0;
         bad_cnt      <= '0;
         i            <= '0;
         count_q      <= '0;
         b_q          <= '0;
         ax_q         <= '0;
         ay_q         <= '0;
         bx_q         <= '0;
         by_q         <= '0;
         len_q        <= '0;
         hop_q        <= '0;
         cls_q        <= CLS_VALID;
         mem.reEA     <= 1'b0;
         mem.reEB     <= 1'b0;
         mem.rePX     <= 1'b0;
         mem.rePY     <= 1'b0;
         mem.addrEA   <= '0;
         mem.addrEB   <= '0;
         mem.addrPX   <= '0;
         mem.addrPY   <= '0;
      end else begin
         busy     <= (next_state != S_IDLE);
         done     <= (next_state == S_DONE);
         mem.reEA <= 1'b0;
         mem.reEB <= 1'b0;
         mem.rePX <= 1'b0;
         mem.rePY <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  sum          <= '0;
                  sum_1hop     <= '0;
                  max_len      <= '0;
                  unplaced_cnt <= '0;
                  bad_cnt      <= '0;
                  count_q      <= edge_count;
                  i            <= '0;
                  if (edge_count != '0) begin
                     mem.reEA   <= 1'b1;
                     mem.reEB   <= 1'b1;
                     mem.addrEA <= '0;
                     mem.addrEB <= '0;
                  end
               end
            end
            S_E_WAIT: begin
               b_q        <= mem.doutEB;
               mem.rePX   <= 1'b1;
               mem.rePY   <= 1'b1;
               mem.addrPX <= mem.doutEA;
               mem.addrPY <= mem.doutEA;
            end
            S_A_WAIT: begin
               ax_q       <= mem.doutPX;
               ay_q       <= mem.doutPY;
               mem.rePX   <= 1'b1;
               mem.rePY   <= 1'b1;
               mem.addrPX <= b_q;
               mem.addrPY <= b_q;
            end
            S_B_WAIT: begin
               bx_q <= mem.doutPX;
               by_q <= mem.doutPY;
            end
            S_CALC: begin
               len_q <= cost_len;
               hop_q <= cost_hop;
               cls_q <= cost_cls;
            end
            S_ACC: begin
               case (cls_q)
                  CLS_VALID: begin
                     sum      <= sum + len_q - W'(1);
                     sum_1hop <= sum_1hop + hop_q;
                     if (len_q > max_len)
                        max_len <= len_q;
                  end
                  CLS_UNPLACED: unplaced_cnt <= unplaced_cnt + CNT_W'(1);
                  default:      bad_cnt      <= bad_cnt + CNT_W'(1);
               endcase
               i <= i_next;
               if (!last_edge) begin
                  mem.reEA   <= 1'b1;
                  mem.reEB   <= 1'b1;
                  mem.addrEA <= W'(i_next);
                  mem.addrEB <= W'(i_next);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_placement_eval.sv
// Directed and randomised checks of placement_eval against behavioural memories
// and an expected-result queue.
module tb_placement_eval;
   import placement_pkg::*;

   localparam int N     = 7;
   localparam int W     = 32;
   localparam int CNT_W = 16;

   typedef struct {
      logic [W-1:0]     sum;
      logic [W-1:0]     hop;
      logic [W-1:0]     maxl;
      logic [CNT_W-1:0] unp;
      logic [CNT_W-1:0] bad;
      int               cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] edge_count;
   logic             busy, done;
   logic [W-1:0]     sum, sum_1hop, max_len;
   logic [CNT_W-1:0] unplaced_cnt, bad_cnt;
   state_t           state_dbg;

   placement_eval_if #(.W(W)) mif ();

   placement_eval #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .edge_count   (edge_count),
      .busy         (busy),
      .done         (done),
      .mem          (mif),
      .sum          (sum),
      .sum_1hop     (sum_1hop),
      .max_len      (max_len),
      .unplaced_cnt (unplaced_cnt),
      .bad_cnt      (bad_cnt),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memories ----------------
   logic [W-1:0] rom_a [16];
   logic [W-1:0] rom_b [16];
   logic [W-1:0] pos_x [16];
   logic [W-1:0] pos_y [16];

   always @(posedge clk) begin
      if (mif.reEA) mif.doutEA <= rom_a[mif.addrEA[3:0]];
      if (mif.reEB) mif.doutEB <= rom_b[mif.addrEB[3:0]];
      if (mif.rePX) mif.doutPX <= pos_x[mif.addrPX[3:0]];
      if (mif.rePY) mif.doutPY <= pos_y[mif.addrPY[3:0]];
   end

   int ea_pulses   = 0;
   int px_pulses   = 0;
   int done_pulses = 0;

   always @(posedge clk) begin
      ea_pulses   <= ea_pulses + int'(mif.reEA);
      px_pulses   <= px_pulses + int'(mif.rePX);
      done_pulses <= done_pulses + int'(done);
   end

   // ---------------- scoreboard ----------------
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int s, input int h, input int m,
                               input int u, input int b, input int cyc);
      exp_t e;
      e.sum  = W'(s);
      e.hop  = W'(h);
      e.maxl = W'(m);
      e.unp  = CNT_W'(u);
      e.bad  = CNT_W'(b);
      e.cyc  = cyc;
      return e;
   endfunction

   // Independent integer model used for the randomised run.
   function automatic exp_t model(input int cnt);
      int s = 0, h = 0, m = 0, u = 0, b = 0;
      for (int k = 0; k < cnt; k++) begin
         int na = int'(rom_a[k]);
         int nb = int'(rom_b[k]);
         int ax = int'($signed(pos_x[na]));
         int ay = int'($signed(pos_y[na]));
         int bx = int'($signed(pos_x[nb]));
         int by = int'($signed(pos_y[nb]));
         if (ax == -1 || ay == -1 || bx == -1 || by == -1)
            u++;
         else if (ax < 0 || ay < 0 || bx < 0 || by < 0 ||
                  ax >= N || ay >= N || bx >= N || by >= N)
            b++;
         else begin
            int dx = (ax > bx) ? ax - bx : bx - ax;
            int dy = (ay > by) ? ay - by : by - ay;
            s += dx + dy - 1;
            h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
            if (dx + dy > m) m = dx + dy;
         end
      end
      return mk(s, h, m, u, b, 8 * cnt + 1);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_edge(input int k, input int a, input int b);
      rom_a[k] = W'(a);
      rom_b[k] = W'(b);
   endtask

   task automatic set_pos(input int n, input int x, input int y);
      pos_x[n] = W'(x);
      pos_y[n] = W'(y);
   endtask

   task automatic run_eval(input string tag, input int cnt, input exp_t e_in, input int repulse);
      exp_t e;
      int   cyc;
      bit   seen;
      int   ea0, px0, d0;
      exp_q.push_back(e_in);
      ea0 = ea_pulses;
      px0 = px_pulses;
      @(negedge clk);
      edge_count = CNT_W'(cnt);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_c1"}, 64'(busy), 64'd1);
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc <= 8 * cnt + 40) begin
         if (done)
            seen = 1'b1;
         else begin
            if (cyc == repulse) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
      end
      e = exp_q.pop_front();
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      check({tag, "_sum"}, 64'(sum), 64'(e.sum));
      check({tag, "_sum_1hop"}, 64'(sum_1hop), 64'(e.hop));
      check({tag, "_max_len"}, 64'(max_len), 64'(e.maxl));
      check({tag, "_unplaced"}, 64'(unplaced_cnt), 64'(e.unp));
      check({tag, "_bad"}, 64'(bad_cnt), 64'(e.bad));
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_ea_strobes"}, 64'(ea_pulses - ea0), 64'(cnt));
      check({tag, "_px_strobes"}, 64'(px_pulses - px0), 64'(2 * cnt));
      d0 = done_pulses;
      repeat (12) @(negedge clk);
      check({tag, "_no_extra_done"}, 64'(done_pulses - d0), 64'd0);
      check({tag, "_results_hold"}, 64'(sum), 64'(e.sum));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int d0;
      reset      = 1'b1;
      start      = 1'b0;
      edge_count = '0;
      for (int k = 0; k < 16; k++) begin
         set_edge(k, 0, 0);
         set_pos(k, 0, 0);
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(S_IDLE));
      check("rst_strobe", 64'(mif.reEA), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single edge.
      set_edge(0, 0, 1);
      set_pos(0, 0, 0);
      set_pos(1, 3, 4);
      run_eval("single", 1, mk(6, 3, 7, 0, 0, 9), 0);

      // Two unit edges.
      set_edge(0, 0, 1);
      set_edge(1, 1, 2);
      set_pos(0, 0, 0);
      set_pos(1, 1, 0);
      set_pos(2, 1, 1);
      run_eval("two", 2, mk(0, 0, 1, 0, 0, 17), 0);

      // Unplaced plus off-grid.
      set_edge(0, 0, 1);
      set_edge(1, 2, 3);
      set_pos(0, 0, 0);
      set_pos(1, -1, -1);
      set_pos(2, 7, 2);
      set_pos(3, 0, 0);
      run_eval("skip", 2, mk(0, 0, 0, 1, 1, 17), 0);

      // Empty edge list clears previous results.
      run_eval("empty", 0, mk(0, 0, 0, 0, 0, 1), 0);

      // Self-loop.
      set_edge(0, 2, 2);
      set_pos(2, 1, 1);
      run_eval("self", 1, mk(-1, -1, 0, 0, 0, 9), 0);

      // Start re-pulsed mid-run is ignored.
      set_edge(0, 0, 1);
      set_edge(1, 1, 2);
      set_edge(2, 2, 0);
      set_pos(0, 0, 0);
      set_pos(1, 1, 0);
      set_pos(2, 1, 1);
      run_eval("repulse", 3, mk(1, 1, 2, 0, 0, 25), 4);

      // Randomised tables including -1 and off-grid coordinates.
      for (int k = 0; k < 8; k++) begin
         set_pos(k, int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 9)) - 1);
      end
      for (int k = 0; k < 6; k++) begin
         set_edge(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      run_eval("random", 6, model(6), 0);

      // Reset in the middle of a run.
      set_edge(0, 0, 1);
      set_edge(1, 1, 2);
      set_edge(2, 2, 0);
      set_pos(0, 0, 0);
      set_pos(1, 3, 4);
      set_pos(2, 1, 1);
      @(negedge clk);
      edge_count = CNT_W'(3);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("midrst_partial_sum", 64'(sum), 64'd6);
      d0    = done_pulses;
      reset = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_sum", 64'(sum), 64'd0);
      check("midrst_max", 64'(max_len), 64'd0);
      check("midrst_state", 64'(state_dbg), 64'(S_IDLE));
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst_no_done", 64'(done_pulses - d0), 64'd0);
      check("midrst_idle", 64'(state_dbg), 64'(S_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
